bank_access_sequencer: RTL

Per-bank access controller that sits directly upstream of the bank word-line decoder. It accepts one read or write request at a time over a valid/ready handshake and latches the 10-bit row address. It then drives the decoder's `sel`/`wl_enable` pair and the column-side strobes (`precharge_en`, `write_en`, `sense_en`) through a fixed, parameterised phase sequence. Finally it returns one response per request, carrying captured sense-amp data for reads.

---
 rtl/bank_seq_pkg.sv | 28 ++
 rtl/bank_access_sequencer_if.sv | 27 ++
 rtl/phase_timer.sv | 30 +++
 rtl/bank_access_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/bank_seq_pkg.sv
// Shared types and default timing for the bank access sequencer.
//   bank_seq_state_t : sequencer FSM state encoding
//   BANK_*           : default widths and phase lengths
//   max3             : helper used to size the phase counter
package bank_seq_pkg;

   localparam int unsigned BANK_ADDR_W     = 10;
   localparam int unsigned BANK_DATA_W     = 32;
   localparam int unsigned BANK_PRE_CYCLES = 1;
   localparam int unsigned BANK_WL_CYCLES  = 2;
   localparam int unsigned BANK_SA_CYCLES  = 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRECHARGE = 3'd1,
      ST_WORDLINE  = 3'd2,
      ST_SENSE     = 3'd3,
      ST_RESP      = 3'd4
   } bank_seq_state_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bank_access_sequencer_if.sv
// Request/response handshake bundle between a requester and the sequencer.
//   master : requester side (drives req_*, resp_ready)
//   slave  : sequencer side (drives req_ready, resp_*)
interface bank_access_sequencer_if #(
   parameter int unsigned ADDR_W = bank_seq_pkg::BANK_ADDR_W,
   parameter int unsigned DATA_W = bank_seq_pkg::BANK_DATA_W
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic              resp_we;
   logic [DATA_W-1:0] resp_data;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_we, resp_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_we, resp_data
   );
endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter with a registered zero flag.
//   clk, rst : clock, synchronous active-high reset
//   load     : load load_val this edge (overrides counting)
//   load_val : phase length minus one
//   zero     : high while the count is 0
module phase_timer #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);
   logic [WIDTH-1:0] count;

   // zero is precomputed so the FSM sees it straight from a flop
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         zero  <= 1'b1;
      end else if (load) begin
         count <= load_val;
         zero  <= (load_val == '0);
      end else if (!zero) begin
         count <= count - WIDTH'(1);
         zero  <= (count == WIDTH'(1));
      end
   end
endmodule

// File: rtl/bank_access_sequencer.sv
// Per-bank access sequencer: accepts one request, steps the decoder and
// column strobes through precharge / word-line / sense phases, returns one
// response per request.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : request/response handshake (slave side)
//   sel          : registered row select to decoder
//   wl_enable    : word-line enable
//   precharge_en : bit-line precharge strobe
//   write_en     : write-driver enable (only with wl_enable)
//   wdata        : registered write data
//   sense_en     : sense-amp enable
//   sa_out       : sense-amp data, captured on the last sense cycle
module bank_access_sequencer
   import bank_seq_pkg::*;
#(
   parameter int unsigned ADDR_W     = BANK_ADDR_W,
   parameter int unsigned DATA_W     = BANK_DATA_W,
   parameter int unsigned PRE_CYCLES = BANK_PRE_CYCLES,
   parameter int unsigned WL_CYCLES  = BANK_WL_CYCLES,
   parameter int unsigned SA_CYCLES  = BANK_SA_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   bank_access_sequencer_if.slave bus,
   output logic [ADDR_W-1:0]      sel,
   output logic                   wl_enable,
   output logic                   precharge_en,
   output logic                   write_en,
   output logic [DATA_W-1:0]      wdata,
   output logic                   sense_en,
   input  logic [DATA_W-1:0]      sa_out
);
   localparam int unsigned MAX_LEN = max3(PRE_CYCLES, WL_CYCLES, SA_CYCLES);
   localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

   bank_seq_state_t   state, next_state;
   logic              phase_zero, phase_load;
   logic [CNT_W-1:0]  phase_len;
   logic              accept, capture;

   logic              req_ready_q, resp_valid_q, resp_we_q;
   logic [DATA_W-1:0] resp_data_q;
   logic              pre_d, wl_d, wen_d, sense_d, resp_valid_d, req_ready_d;

   assign accept  = (state == ST_IDLE) && bus.req_valid;
   assign capture = (state == ST_SENSE) && phase_zero;

   phase_timer #(.WIDTH(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (phase_load),
      .load_val (phase_len),
      .zero     (phase_zero)
   );

   // State register plus registered outputs and datapath captures
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         req_ready_q  <= 1'b1;
         precharge_en <= 1'b0;
         wl_enable    <= 1'b0;
         write_en     <= 1'b0;
         sense_en     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_we_q    <= 1'b0;
         sel          <= '0;
         wdata        <= '0;
         resp_data_q  <= '0;
      end else begin
         state        <= next_state;
         req_ready_q  <= req_ready_d;
         precharge_en <= pre_d;
         wl_enable    <= wl_d;
         write_en     <= wen_d;
         sense_en     <= sense_d;
         resp_valid_q <= resp_valid_d;
         if (accept) begin
            sel         <= bus.req_addr;
            wdata       <= bus.req_wdata;
            resp_we_q   <= bus.req_we;
            resp_data_q <= '0;
         end
         if (capture) begin
            resp_data_q <= sa_out;
         end
      end
   end

   // Next-state logic; phases advance when the timer reads zero
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:      if (bus.req_valid) next_state = ST_PRECHARGE;
         ST_PRECHARGE: if (phase_zero) next_state = ST_WORDLINE;
         ST_WORDLINE:  if (phase_zero) next_state = resp_we_q ? ST_RESP : ST_SENSE;
         ST_SENSE:     if (phase_zero) next_state = ST_RESP;
         ST_RESP:      if (bus.resp_ready) next_state = ST_IDLE;
         default:      next_state = ST_IDLE;
      endcase
   end

   // Output decode from next state so strobes come straight out of flops
   always_comb begin
      pre_d        = (next_state == ST_PRECHARGE);
      wl_d         = (next_state == ST_WORDLINE);
      wen_d        = (next_state == ST_WORDLINE) && resp_we_q;
      sense_d      = (next_state == ST_SENSE);
      resp_valid_d = (next_state == ST_RESP);
      req_ready_d  = (next_state == ST_IDLE);
      phase_load   = (next_state != state);
      phase_len    = '0;
      case (next_state)
         ST_PRECHARGE: phase_len = CNT_W'(PRE_CYCLES - 1);
         ST_WORDLINE:  phase_len = CNT_W'(WL_CYCLES - 1);
         ST_SENSE:     phase_len = CNT_W'(SA_CYCLES - 1);
         default:      phase_len = '0;
      endcase
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_we    = resp_we_q;
   assign bus.resp_data  = resp_data_q;
endmodule
